// File: rtl/hazard_ctrl_p.sv
// hazard_ctrl_p: load-use / multdiv hazard stall control beside decode; HAZ_PERF_CNT_EN adds the perf_stalls counter
module hazard_ctrl_p #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic              use_rs_d,
  input  logic              use_rt_d,
  input  logic              is_store_d,
  input  logic              is_md_d,
  input  logic              ld_x,
  input  logic [REG_AW-1:0] rd_x,
  input  logic              md_start_x,
  input  logic [REG_AW-1:0] md_rd_x,
  input  logic              flush_x,
  output logic              stall_fd,
  output logic              bubble_dx,
  output logic              md_busy,
  output logic              md_wb,
  output logic [REG_AW-1:0] md_rd,
  output logic [31:0]       perf_stalls
);
  typedef enum logic {IDLE, LD_WAIT} state_t;
  state_t     state, state_nx;
  logic [3:0] ld_cnt, ld_cnt_nx;
  logic [5:0] md_cnt;
  logic       ld_hit, md_hit, stall;
  assign ld_hit = ld_x & (rd_x != '0) &
                  ((use_rs_d & (rs_d == rd_x)) | (use_rt_d & (rt_d == rd_x) & ~is_store_d));
  assign md_hit = md_busy & (((md_rd != '0) &
                  ((use_rs_d & (rs_d == md_rd)) | (use_rt_d & (rt_d == md_rd)))) | is_md_d);
  // gated by reset_n so every output reads 0 the moment reset asserts
  assign stall     = reset_n & ~flush_x & (ld_hit | (state == LD_WAIT) | md_hit);
  assign stall_fd  = stall;
  assign bubble_dx = stall;
  always_comb begin
    state_nx  = flush_x ? IDLE :
                (state == IDLE) ? ((ld_hit && LOAD_LAT > 1) ? LD_WAIT : IDLE) :
                ((ld_cnt > 4'd1) ? LD_WAIT : IDLE);
    ld_cnt_nx = flush_x ? 4'd0 :
                (state == IDLE) ? (ld_hit ? 4'(LOAD_LAT - 1) : 4'd0) :
                ((ld_cnt != 4'd0) ? ld_cnt - 4'd1 : 4'd0);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      ld_cnt <= 4'd0;
    end else begin
      state  <= state_nx;
      ld_cnt <= ld_cnt_nx;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      md_busy <= 1'b0;
      md_cnt  <= 6'd0;
      md_rd   <= '0;
    end else if (!md_busy) begin
      if (md_start_x) begin
        md_busy <= 1'b1;
        md_cnt  <= 6'(MD_LAT);
        md_rd   <= md_rd_x;
      end
    end else if (md_cnt <= 6'd1) begin
      md_busy <= 1'b0;
      md_cnt  <= 6'd0;
      md_rd   <= '0;
    end else begin
      md_cnt <= md_cnt - 6'd1;
    end
  assign md_wb = md_busy & (md_cnt == 6'd1);
  // a second issue while busy is dropped by the scoreboard; flag it in simulation
  assert property (@(posedge clock) disable iff (!reset_n) !(md_start_x && md_busy))
    else $warning("hazard_ctrl_p: md_start_x while md_busy ignored");
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) perf_q <= 32'd0;
    else if (stall) perf_q <= perf_q + 32'd1;
  assign perf_stalls = perf_q;
`else
  assign perf_stalls = 32'd0;
`endif
endmodule
